// File: rtl/floyd_warshall_path_loader.sv
// floyd_warshall_path_loader: streams path words into shared memory, optionally verifies them, then pulses t.
// Optional readback verification is compiled in with `define PATH_LOADER_READBACK_EN.
module floyd_warshall_path_loader #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              mem_rd_en,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic              t,
  output logic              busy,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, START} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic hs, last, sum_ok;
  assign hs = (state_q == LOAD) && in_valid;
  assign last = cnt_q == ADDR_W'(SIZE - 1);
  assign in_ready = state_q == LOAD;
  assign mem_wr_en = hs;
  assign mem_wr_data = hs ? in_data : '0;
  assign mem_addr = cnt_q;
  assign busy = state_q != IDLE;
  assign t = state_q == START;
`ifdef PATH_LOADER_READBACK_EN
  logic [WIDTH-1:0] ld_sum_q, ld_sum_d, rb_sum_q, rb_sum_d;
  logic rd_pend_q, err_q, err_d;
  assign mem_rd_en = state_q == VERIFY;
  assign err = err_q;
  // Read data lags the request by one cycle, so accumulate on the pending flag.
  always_comb begin
    ld_sum_d = hs ? ld_sum_q + in_data : ld_sum_q;
    rb_sum_d = rd_pend_q ? rb_sum_q + mem_rd_data : rb_sum_q;
    sum_ok = rb_sum_d == ld_sum_q;
    err_d = (state_q == CHECK && !sum_ok) ? 1'b1 : err_q;
    if (state_q == IDLE && load_req) begin
      ld_sum_d = '0;
      rb_sum_d = '0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_sum_q <= '0;
      rb_sum_q <= '0;
      rd_pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ld_sum_q <= ld_sum_d;
      rb_sum_q <= rb_sum_d;
      rd_pend_q <= state_q == VERIFY;
      err_q <= err_d;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^mem_rd_data;
  assign sum_ok = 1'b0;
  assign mem_rd_en = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (load_req) begin
        state_d = LOAD;
        cnt_d = '0;
      end
      LOAD: if (hs) begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
`ifdef PATH_LOADER_READBACK_EN
        if (last) state_d = VERIFY;
`else
        if (last) state_d = START;
`endif
      end
      VERIFY: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = CHECK;
      end
      CHECK: state_d = sum_ok ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_floyd_warshall_path_loader.sv
// tb_floyd_warshall_path_loader: directed bench with a behavioural path memory.
module tb_floyd_warshall_path_loader;
  localparam int SIZE = 64;
`ifdef PATH_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 0, rst = 1, load_req = 0, in_valid = 0;
  logic [31:0] in_data = 0, mem_wr_data, mem_rd_data = 0;
  logic [5:0] mem_addr;
  logic in_ready, mem_wr_en, mem_rd_en, t, busy, err;
  logic corrupt = 0;
  logic [31:0] mem [SIZE];
  int checks = 0, errors = 0;
  floyd_warshall_path_loader dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .t(t), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= (corrupt && mem_addr == 6'd32) ? 32'd0 : mem[mem_addr];
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wr_data"}, mem_wr_data, 0);
    chk({tag, "_t"}, t, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask
  // Drives one load sequence; alt toggles in_valid, pulse injects load_req during LOAD and START.
  task automatic run_seq(input string tag, input bit alt, input bit pulse, input bit bad);
    int nw = 0, nr = 0, tcnt = 0, tcyc = -1, exp_t, c;
    bit done = 0;
    exp_t = (alt ? 2 * SIZE - 1 : SIZE) + (RB ? SIZE + 1 : 0) + 1;
    corrupt = bad;
    load_req = 1;
    in_valid = 0;
    tick();
    for (c = 1; c < 400 && !done; c++) begin
      in_valid = alt ? (c % 2 == 1) : 1'b1;
      in_data = nw + 1;
      load_req = pulse && (c == 10 || c == exp_t);
      #1;
      if (c == 1) chk({tag, "_err_cleared"}, err, 0);
      if (c <= 3 || nw == SIZE - 1) chk({tag, "_in_ready"}, in_ready, nw < SIZE);
      if (mem_wr_en !== (in_valid && nw < SIZE)) chk({tag, "_wr_en"}, mem_wr_en, in_valid && nw < SIZE);
      if (mem_wr_en) begin
        if (mem_addr !== 6'(nw)) chk({tag, "_wr_addr"}, mem_addr, nw);
        if (mem_wr_data !== 32'(nw + 1)) chk({tag, "_wr_data"}, mem_wr_data, nw + 1);
        nw++;
      end
      if (mem_rd_en) begin
        if (mem_addr !== 6'(nr)) chk({tag, "_rd_addr"}, mem_addr, nr);
        nr++;
      end
      if (t) begin
        tcnt++;
        tcyc = c;
      end
      if (!busy) done = 1;
      else tick();
    end
    load_req = 0;
    in_valid = 0;
    chk({tag, "_terminated"}, done, 1);
    chk({tag, "_writes"}, nw, SIZE);
    chk({tag, "_reads"}, nr, RB ? SIZE : 0);
    chk({tag, "_t_count"}, tcnt, bad ? 0 : 1);
    if (!bad) chk({tag, "_t_cycle"}, tcyc, exp_t);
    chk({tag, "_err"}, err, bad);
    chk({tag, "_busy_end"}, busy, 0);
    tick();
    corrupt = 0;
  endtask
  initial begin
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 0;
    tick();
    chk_idle_outputs("idle");
    run_seq("plain", 0, 0, 0);
    for (int i = 0; i < SIZE; i++)
      if (mem[i] !== 32'(i + 1)) chk("mem_contents", mem[i], i + 1);
    chk("mem_first", mem[0], 1);
    chk("mem_last", mem[SIZE-1], SIZE);
    run_seq("pulse", 0, 1, 0);
    run_seq("alt", 1, 0, 0);
    load_req = 1;
    tick();
    load_req = 0;
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'(100 + i);
      tick();
    end
    chk("pre_rst_addr", mem_addr, 20);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    tick();
    chk_idle_outputs("mid_rst");
    rst = 0;
    in_valid = 0;
    tick();
    chk_idle_outputs("post_rst");
    run_seq("after_rst", 0, 0, 0);
`ifdef PATH_LOADER_READBACK_EN
    run_seq("corrupt", 0, 0, 1);
    chk("corrupt_err_sticky", err, 1);
    run_seq("recover", 0, 0, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
